ps2_receiver: RTL and testbench
===============================

Name: ps2_receiver

Overview:
- PS/2 device-to-host byte deframer sitting directly upstream of the mouse packet state machine.
- Synchronises and glitch-filters the raw ps2_clk/ps2_data pins and samples the 11-bit frame on filtered clock falling edges.
- Checks start, odd parity and stop bits.
- Delivers each good byte as a one-cycle scan_code_ready pulse with scan_code_out, directly compatible with that state machine's scan_code_ready/scan_code_in inputs.
- Aborts stalled frames on timeout.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronised samples needed before the filtered ps2_clk changes level.
- TIMEOUT_CYCLES, 100000: clk cycles without a filtered falling edge, mid-frame, before the frame is aborted.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- ps2_clk  input  1  raw PS/2 clock pin, asynchronous to clk.
- ps2_data  input  1  raw PS/2 data pin, asynchronous to clk.
- scan_code_ready  output  1  one-cycle pulse: scan_code_out holds a new valid byte.
- scan_code_out  output  8  last valid received byte, LSB first on the wire.
- frame_error  output  1  one-cycle pulse on bad start (in frame), parity, stop, or timeout.
- busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (reset=0, asynchronous): every output is 0, state is IDLE, and the shift register, counters and filter are cleared. Filtered clock and both synchroniser stages reset to 1 (bus idle high).
- Reset asserted mid-frame drops the partial frame silently, with no error pulse.
- Sync: two-flop synchroniser on each pin.
- Filter: a saturating counter 0..FILTER_LEN-1 counts while the synchronised clock differs from the filtered level. When it reaches FILTER_LEN-1, the filtered level flips and the counter clears. Any agreeing sample clears the counter, so pulses shorter than FILTER_LEN cycles are ignored.
- Edge: fall_strobe lasts one cycle when the filtered clock goes 1->0. The data bit is the synchronised ps2_data sampled in that same cycle.
- States are IDLE, DATA, PARITY, STOP:
  - IDLE: on fall_strobe, data=0 goes to DATA with bit_count=0 and the timeout counter cleared. data=1 stays in IDLE with no error, as a stray edge.
  - DATA: each fall_strobe shifts the bit into shift[7] with a right shift, so the LSB arrives first. After the 8th bit (bit_count=7), go to PARITY.
  - PARITY: latch the bit and go to STOP.
  - STOP: on fall_strobe, return to IDLE. If stop=1 and the XOR of the 8 data bits and the parity bit = 1 (odd parity), the byte is good. Otherwise frame_error pulses.
- Output timing: on a good byte, scan_code_out updates and scan_code_ready pulses in the cycle after the stop-bit fall_strobe (latency 1 clk). scan_code_out holds its value until the next good byte. Errors never change scan_code_out.
- Timeout:
  - In DATA, PARITY or STOP, the counter increments every cycle and clears on each fall_strobe.
  - Reaching TIMEOUT_CYCLES-1 forces IDLE and pulses frame_error. Timeout takes priority over a coincident fall_strobe.
  - Counter width is $clog2(TIMEOUT_CYCLES).
- scan_code_ready and frame_error are never high in the same cycle. Back-to-back frames need no gap beyond the PS/2 idle time.
- The block is receive-only: it never drives the pins, and host-to-device inhibit is handled elsewhere.

Decomposition:
- Shared constants package (alongside constant.v): PS2_STATE_* encodings (2 bits), PS2_FRAME_BITS=11, and the TRUE/FALSE already in constant.v.
- One natural sub-module, ps2_input_filter: two-flop synchroniser plus debounce for one pin, producing level and fall_strobe. It is instantiated for ps2_clk; ps2_data uses only its synchroniser path.

Test Plan:
- Frame 0x08 (start 0, bits 0,0,0,1,0,0,0,0, parity 0, stop 1) at a 12 kHz PS/2 clock -> one scan_code_ready pulse, scan_code_out=0x08, frame_error never 1.
- Frames 0xFA (parity 1) and 0x00 (parity 1) back-to-back -> two ready pulses in order. scan_code_out is 0xFA, then 0x00.
- 0x55 sent with parity 0 (wrong) -> frame_error pulse, no ready pulse, scan_code_out keeps its previous value.
- 3-cycle low glitch on ps2_clk while in IDLE, plus a 5-cycle glitch mid-frame with FILTER_LEN=8 -> no edge counted, next valid 0x3C frame received correctly.
- Stop after 4 data bits, ps2_clk held high -> frame_error exactly TIMEOUT_CYCLES cycles after the last fall_strobe (within sync/filter latency), busy drops. A following 0xAA frame is received correctly.
- Assert reset after 6 bits, release, then send 0x12 -> no error pulse, all outputs 0 during reset, 0x12 received.

Source files
------------

// File: rtl/ps2_receiver_pkg.sv
// rtl/ps2_receiver_pkg.sv - shared constants, state encoding and parity helper for the PS/2 receiver
// Purpose: frame geometry, FSM state encoding and boolean constants used by the receiver.
// Ports: none (package).
package ps2_receiver_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Start + 8 data + parity + stop.
  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_DATA_BITS  = PS2_FRAME_BITS - 3;

  typedef enum logic [1:0] {
    PS2_STATE_IDLE   = 2'd0,
    PS2_STATE_DATA   = 2'd1,
    PS2_STATE_PARITY = 2'd2,
    PS2_STATE_STOP   = 2'd3
  } ps2_state_t;

  // Odd parity: the data bits plus the parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_receiver_if.sv
// rtl/ps2_receiver_if.sv - received-byte output bundle of the PS/2 receiver
// Purpose: carries deframed bytes and status toward the mouse packet state machine.
// Ports: scan_code_ready (byte pulse), scan_code_out (byte), frame_error (error pulse), busy (frame in progress).
// master = receiver side (drives), slave = consumer side.
interface ps2_receiver_if;

  logic       scan_code_ready;
  logic [7:0] scan_code_out;
  logic       frame_error;
  logic       busy;

  modport master (
    output scan_code_ready,
    output scan_code_out,
    output frame_error,
    output busy
  );

  modport slave (
    input scan_code_ready,
    input scan_code_out,
    input frame_error,
    input busy
  );

endinterface

// File: rtl/ps2_input_filter.sv
// rtl/ps2_input_filter.sv - synchroniser plus debounce for one PS/2 pin
// Purpose: produces a glitch-filtered level and a one-cycle strobe on each filtered 1->0 transition.
// Ports: clk, reset (async, active-low), pin (raw input), level (filtered level), fall_strobe (1->0 pulse).
module ps2_input_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic fall_strobe
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic          sync;
  logic [CW-1:0] count;

  ps2_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .pin   (pin),
    .sync  (sync)
  );

  // The level only flips after FILTER_LEN consecutive disagreeing samples;
  // any agreeing sample restarts the run, so short pulses never get through.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level       <= 1'b1;
      count       <= '0;
      fall_strobe <= 1'b0;
    end else begin
      fall_strobe <= 1'b0;
      if (sync != level) begin
        if (count == CNT_LAST) begin
          level       <= sync;
          count       <= '0;
          fall_strobe <= level;
        end else begin
          count <= count + 1'b1;
        end
      end else begin
        count <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_sync.sv
// rtl/ps2_sync.sv - two-flop synchroniser for one raw PS/2 pin
// Purpose: brings an asynchronous pin into the clk domain; resets to the idle-high bus level.
// Ports: clk, reset (async, active-low), pin (raw input), sync (synchronised output).
module ps2_sync (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic sync
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      sync <= 1'b1;
    end else begin
      meta <= pin;
      sync <= meta;
    end
  end

endmodule

// File: rtl/ps2_receiver.sv
// rtl/ps2_receiver.sv - PS/2 device-to-host byte deframer with parity/stop checks and timeout
// Purpose: samples 11-bit frames on filtered ps2_clk falling edges and emits good bytes or error pulses.
// Ports: clk, reset (async, active-low), ps2_clk/ps2_data (raw pins),
//        rx (master modport: scan_code_ready, scan_code_out, frame_error, busy).
module ps2_receiver
  import ps2_receiver_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ps2_clk,
  input  logic           ps2_data,
  ps2_receiver_if.master rx
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    LAST_BIT     = 3'(PS2_DATA_BITS - 1);

  ps2_state_t              state;
  logic [2:0]              bit_count;
  logic [PS2_DATA_BITS-1:0] shift;
  logic                    parity_bit;
  logic [TW-1:0]           timeout_cnt;
  logic                    ready_q;
  logic                    error_q;
  logic [7:0]              code_q;

  logic clk_level;
  logic fall_strobe;
  logic data_bit;

  ps2_input_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk         (clk),
    .reset       (reset),
    .pin         (ps2_clk),
    .level       (clk_level),
    .fall_strobe (fall_strobe)
  );

  // Data only changes while ps2_clk is high, so it needs no debounce.
  ps2_sync u_data_sync (
    .clk   (clk),
    .reset (reset),
    .pin   (ps2_data),
    .sync  (data_bit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= PS2_STATE_IDLE;
      bit_count   <= '0;
      shift       <= '0;
      parity_bit  <= FALSE;
      timeout_cnt <= '0;
      ready_q     <= FALSE;
      error_q     <= FALSE;
      code_q      <= '0;
    end else begin
      ready_q <= FALSE;
      error_q <= FALSE;
      if (state == PS2_STATE_IDLE) begin
        timeout_cnt <= '0;
        // A falling edge with data high is a stray edge, not a start bit.
        if (fall_strobe && !data_bit) begin
          state     <= PS2_STATE_DATA;
          bit_count <= '0;
        end
      end else if (timeout_cnt == TIMEOUT_LAST) begin
        // Timeout wins over a coincident edge.
        state       <= PS2_STATE_IDLE;
        timeout_cnt <= '0;
        error_q     <= TRUE;
      end else if (fall_strobe) begin
        timeout_cnt <= '0;
        case (state)
          PS2_STATE_DATA: begin
            shift     <= {data_bit, shift[PS2_DATA_BITS-1:1]};
            bit_count <= bit_count + 3'd1;
            if (bit_count == LAST_BIT) state <= PS2_STATE_PARITY;
          end
          PS2_STATE_PARITY: begin
            parity_bit <= data_bit;
            state      <= PS2_STATE_STOP;
          end
          default: begin
            state <= PS2_STATE_IDLE;
            if (data_bit && odd_parity_ok(shift, parity_bit)) begin
              code_q  <= shift;
              ready_q <= TRUE;
            end else begin
              error_q <= TRUE;
            end
          end
        endcase
      end else begin
        timeout_cnt <= timeout_cnt + 1'b1;
      end
    end
  end

  assign rx.scan_code_ready = ready_q;
  assign rx.scan_code_out   = code_q;
  assign rx.frame_error     = error_q;
  assign rx.busy            = (state != PS2_STATE_IDLE);

endmodule

// File: tb/tb_ps2_receiver.sv
// tb/tb_ps2_receiver.sv - scoreboard testbench for ps2_receiver
module tb_ps2_receiver;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 400;
  localparam int HALF           = 20;
  localparam int IDLE_GAP       = 60;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic ps2_clk;
  logic ps2_data;

  int compared   = 0;
  int mismatched = 0;
  int cycle      = 0;
  int last_fall_cycle = 0;
  logic [7:0] hold_model = 8'h00;
  exp_t exp_q[$];

  ps2_receiver_if rx_if ();

  ps2_receiver #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx       (rx_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every output pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (reset) begin
      if (rx_if.scan_code_ready && rx_if.frame_error)
        check("ready_and_error_together", 32'd1, 32'd0);
      if (rx_if.scan_code_ready || rx_if.frame_error) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output_kind", {31'd0, rx_if.frame_error}, 32'hFFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("event_is_error", {31'd0, rx_if.frame_error}, {31'd0, e.is_err});
          if (!e.is_err) begin
            check("scan_code_out", {24'd0, rx_if.scan_code_out}, {24'd0, e.data});
            hold_model = e.data;
          end else begin
            check("scan_code_hold_on_error", {24'd0, rx_if.scan_code_out}, {24'd0, hold_model});
          end
        end
      end
    end
  end

  task automatic send_bit(input logic b, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      wait_cycles(6);
      ps2_clk = 1'b0;
      wait_cycles(5);
      ps2_clk = 1'b1;
      wait_cycles(HALF - 11);
    end else begin
      wait_cycles(HALF);
    end
    last_fall_cycle = cycle;
    ps2_clk = 1'b0;
    wait_cycles(HALF);
    ps2_clk = 1'b1;
  endtask

  // Reference: odd parity means the parity bit makes the total count of ones odd.
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                            input int glitch_bit, input int gap);
    logic [10:0] bits;
    logic        par;
    exp_t        e;
    par  = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    if (bad_par) par = ~par;
    bits = {~bad_stop, par, d, 1'b0};
    e.is_err = bad_par || bad_stop;
    e.data   = d;
    exp_q.push_back(e);
    for (int k = 0; k < 11; k++) send_bit(bits[k], k == glitch_bit);
    ps2_data = 1'b1;
    wait_cycles(gap);
  endtask

  task automatic send_partial(input logic [7:0] d, input int nbits);
    send_bit(1'b0, 1'b0);
    for (int k = 0; k < nbits; k++) send_bit(d[k], 1'b0);
    ps2_data = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    wait_cycles(5);
    check(name, exp_q.size(), 32'd0);
  endtask

  task automatic check_outputs_zero(input string name);
    @(negedge clk);
    check(name, {21'd0, rx_if.scan_code_ready, rx_if.scan_code_out, rx_if.frame_error, rx_if.busy}, 32'd0);
  endtask

  initial begin
    reset    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cycles(5);
    check_outputs_zero("reset_outputs");
    reset = 1'b1;
    wait_cycles(20);

    send_frame(8'h08, 1'b0, 1'b0, -1, IDLE_GAP);
    drain("frame_08_drained");

    send_frame(8'hFA, 1'b0, 1'b0, -1, HALF);
    send_frame(8'h00, 1'b0, 1'b0, -1, IDLE_GAP);
    drain("back_to_back_drained");

    send_frame(8'h55, 1'b1, 1'b0, -1, IDLE_GAP);
    drain("bad_parity_drained");

    ps2_clk = 1'b0;
    wait_cycles(3);
    ps2_clk = 1'b1;
    wait_cycles(30);
    check("idle_glitch_no_busy", {31'd0, rx_if.busy}, 32'd0);
    send_frame(8'h3C, 1'b0, 1'b0, 4, IDLE_GAP);
    drain("glitch_frame_drained");

    begin
      exp_t e;
      int   lat;
      bit   seen;
      e.is_err = 1'b1;
      e.data   = 8'h00;
      exp_q.push_back(e);
      send_partial(8'hAA, 4);
      wait_cycles(15);
      check("busy_mid_frame", {31'd0, rx_if.busy}, 32'd1);
      seen = 1'b0;
      lat  = 0;
      for (int i = 0; i < 2 * TIMEOUT_CYCLES; i++) begin
        @(negedge clk);
        if (rx_if.frame_error) begin
          seen = 1'b1;
          lat  = cycle - last_fall_cycle;
          break;
        end
      end
      check("timeout_seen", {31'd0, seen}, 32'd1);
      check("timeout_latency_in_window",
            {31'd0, (lat >= TIMEOUT_CYCLES && lat <= TIMEOUT_CYCLES + 20)}, 32'd1);
      wait_cycles(2);
      check("busy_after_timeout", {31'd0, rx_if.busy}, 32'd0);
      drain("timeout_drained");
    end
    send_frame(8'hAA, 1'b0, 1'b0, -1, IDLE_GAP);
    drain("after_timeout_drained");

    send_partial(8'h5A, 5);
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(2);
    check_outputs_zero("reset_mid_frame_outputs");
    hold_model = 8'h00;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cycles(5);
    reset = 1'b1;
    wait_cycles(20);
    check("no_pulse_after_reset", exp_q.size(), 32'd0);
    send_frame(8'h12, 1'b0, 1'b0, -1, IDLE_GAP);
    drain("after_reset_drained");

    for (int i = 0; i < 20; i++) begin
      logic [7:0] d;
      int r;
      d = 8'($urandom_range(0, 255));
      r = $urandom_range(0, 9);
      send_frame(d, r < 3, r == 9, -1, $urandom_range(HALF, IDLE_GAP));
    end
    drain("random_drained");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
